// File: rtl/l2_cache_wb.sv
// Set-associative L2 cache with selectable write-back/write-through policy and true-LRU replacement.
// Block-wide transfers on both sides: valid/ready capture from L1, level-held requests to memory.
module l2_cache_wb #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int NUM_SETS    = 16,
  parameter int NUM_WAYS    = 4,
  parameter bit WRITE_BACK  = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              l1_req_valid,
  input  logic                              l1_req_write,
  input  logic [ADDR_WIDTH-1:0]             l1_req_addr,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] l1_req_wdata,
  output logic                              l1_req_ready,
  output logic                              l1_resp_valid,
  output logic                              l1_resp_hit,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] l1_resp_rdata,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_data_out,
  input  logic                              mem_ready,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_data_block
);

  localparam int BLK_W = BLOCK_WORDS * DATA_WIDTH;
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int WAY_W = $clog2(NUM_WAYS);

  typedef enum logic [2:0] {IDLE, TAG_CHECK, WRITEBACK, REFILL, RESPOND} state_t;

  state_t state_q, state_d;

  logic [BLK_W-1:0]    data_mem [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q  [NUM_SETS];
  logic [WAY_W-1:0]    age_q    [NUM_SETS][NUM_WAYS];

  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic                  req_write_q;
  logic [BLK_W-1:0]      req_wdata_q;
  logic [WAY_W-1:0]      way_q, way_d;
  logic                  hit_q, hit_d;
  logic                  wb_victim_q, wb_victim_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [BLK_W-1:0]      mem_data_q, mem_data_d;
  logic [BLK_W-1:0]      resp_data_q, resp_data_d;

  logic [ADDR_WIDTH-1:0] req_blk_addr;
  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  hit, any_inv;
  logic [WAY_W-1:0]      hit_way, lru_way, inv_way, victim_way;
  logic                  victim_dirty;
  logic                  inst_en, inst_dirty, clr_dirty, lru_en;
  logic [BLK_W-1:0]      inst_data;

  // Masking (rather than slicing) keeps every captured address bit in use.
  assign req_blk_addr = req_addr_q & ~ADDR_WIDTH'(BLOCK_WORDS - 1);
  assign req_idx      = req_blk_addr[OFF_W +: IDX_W];
  assign req_tag      = req_blk_addr[ADDR_WIDTH-1 -: TAG_W];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    lru_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (age_q[req_idx][w] == WAY_W'(NUM_WAYS - 1)) lru_way = WAY_W'(w);
    end
    // Descending scan leaves the lowest-index invalid way selected.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    victim_way   = any_inv ? inv_way : lru_way;
    victim_dirty = valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way];
  end

  always_comb begin
    state_d     = state_q;
    way_d       = way_q;
    hit_d       = hit_q;
    wb_victim_d = wb_victim_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    resp_data_d = resp_data_q;
    inst_en     = 1'b0;
    inst_dirty  = 1'b0;
    inst_data   = req_wdata_q;
    clr_dirty   = 1'b0;
    lru_en      = 1'b0;
    case (state_q)
      IDLE: if (l1_req_valid) state_d = TAG_CHECK;
      TAG_CHECK: begin
        hit_d = hit;
        if (hit) begin
          way_d       = hit_way;
          resp_data_d = req_write_q ? req_wdata_q : data_mem[req_idx][hit_way];
          if (!req_write_q) begin
            state_d = RESPOND;
          end else begin
            inst_en    = 1'b1;
            inst_dirty = WRITE_BACK;
            if (WRITE_BACK) begin
              state_d = RESPOND;
            end else begin
              state_d     = WRITEBACK;
              wb_victim_d = 1'b0;
              mem_addr_d  = req_blk_addr;
              mem_data_d  = req_wdata_q;
            end
          end
        end else begin
          way_d       = victim_way;
          resp_data_d = req_wdata_q;
          if (victim_dirty) begin
            state_d     = WRITEBACK;
            wb_victim_d = 1'b1;
            mem_addr_d  = {tag_mem[req_idx][victim_way], req_idx, {OFF_W{1'b0}}};
            mem_data_d  = data_mem[req_idx][victim_way];
          end else if (!req_write_q) begin
            state_d    = REFILL;
            mem_addr_d = req_blk_addr;
          end else begin
            inst_en    = 1'b1;
            inst_dirty = WRITE_BACK;
            if (WRITE_BACK) begin
              state_d = RESPOND;
            end else begin
              state_d     = WRITEBACK;
              wb_victim_d = 1'b0;
              mem_addr_d  = req_blk_addr;
              mem_data_d  = req_wdata_q;
            end
          end
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          if (wb_victim_q) begin
            clr_dirty = 1'b1;
            if (!req_write_q) begin
              state_d    = REFILL;
              mem_addr_d = req_blk_addr;
            end else begin
              inst_en    = 1'b1;
              inst_dirty = WRITE_BACK;
              state_d    = RESPOND;
            end
          end else begin
            state_d = RESPOND;
          end
        end
      end
      REFILL: begin
        if (mem_ready) begin
          inst_en     = 1'b1;
          inst_data   = mem_data_block;
          resp_data_d = mem_data_block;
          state_d     = RESPOND;
        end
      end
      RESPOND: begin
        lru_en  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_write_q <= 1'b0;
      req_wdata_q <= '0;
      way_q       <= '0;
      hit_q       <= 1'b0;
      wb_victim_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      resp_data_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      state_q     <= state_d;
      way_q       <= way_d;
      hit_q       <= hit_d;
      wb_victim_q <= wb_victim_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      resp_data_q <= resp_data_d;
      if (state_q == IDLE && l1_req_valid) begin
        req_addr_q  <= l1_req_addr;
        req_write_q <= l1_req_write;
        req_wdata_q <= l1_req_wdata;
      end
      if (inst_en) begin
        valid_q[req_idx][way_d] <= 1'b1;
        dirty_q[req_idx][way_d] <= inst_dirty;
      end else if (clr_dirty) begin
        dirty_q[req_idx][way_q] <= 1'b0;
      end
      if (lru_en) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == way_q)
            age_q[req_idx][w] <= '0;
          else if (age_q[req_idx][w] < age_q[req_idx][way_q])
            age_q[req_idx][w] <= age_q[req_idx][w] + WAY_W'(1);
        end
      end
    end
  end

  // Line storage is not reset; valid bits guard it.
  always_ff @(posedge clk) begin
    if (inst_en) begin
      data_mem[req_idx][way_d] <= inst_data;
      tag_mem[req_idx][way_d]  <= req_tag;
    end
  end

  assign l1_req_ready  = (state_q == IDLE) && rst_n;
  assign l1_resp_valid = (state_q == RESPOND);
  assign l1_resp_hit   = l1_resp_valid && hit_q;
  assign l1_resp_rdata = resp_data_q;
  assign mem_read      = (state_q == REFILL);
  assign mem_write     = (state_q == WRITEBACK);
  assign mem_addr      = mem_addr_q;
  assign mem_data_out  = mem_data_q;

endmodule

// File: tb/tb_l2_cache_wb.sv
// Directed bench for l2_cache_wb: one write-back and one write-through instance,
// a behavioural block memory with programmable latency, and a table of request vectors.
module tb_l2_cache_wb;

  typedef logic [255:0] blk_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        l1_valid, l1_write;
  logic [15:0] l1_addr;
  blk_t        l1_wdata;
  logic        m_ready;
  blk_t        m_data;

  logic        wb_ready, wb_rv, wb_hit, wb_mr, wb_mw, wb_mrdy;
  logic [15:0] wb_maddr;
  blk_t        wb_rdata, wb_mdo;
  logic        wt_ready, wt_rv, wt_hit, wt_mr, wt_mw, wt_mrdy;
  logic [15:0] wt_maddr;
  blk_t        wt_rdata, wt_mdo;

  logic        a_ready, a_rv, a_hit, a_mr, a_mw;
  logic [15:0] a_maddr;
  blk_t        a_rdata, a_mdo;

  always #5 clk = ~clk;

  assign wb_mrdy = m_ready & ~sel;
  assign wt_mrdy = m_ready & sel;
  assign a_ready = sel ? wt_ready : wb_ready;
  assign a_rv    = sel ? wt_rv    : wb_rv;
  assign a_hit   = sel ? wt_hit   : wb_hit;
  assign a_rdata = sel ? wt_rdata : wb_rdata;
  assign a_mr    = sel ? wt_mr    : wb_mr;
  assign a_mw    = sel ? wt_mw    : wb_mw;
  assign a_maddr = sel ? wt_maddr : wb_maddr;
  assign a_mdo   = sel ? wt_mdo   : wb_mdo;

  l2_cache_wb #(.WRITE_BACK(1'b1)) dut_wb (
    .clk(clk), .rst_n(rst_n),
    .l1_req_valid(l1_valid & ~sel), .l1_req_write(l1_write), .l1_req_addr(l1_addr),
    .l1_req_wdata(l1_wdata), .l1_req_ready(wb_ready),
    .l1_resp_valid(wb_rv), .l1_resp_hit(wb_hit), .l1_resp_rdata(wb_rdata),
    .mem_read(wb_mr), .mem_write(wb_mw), .mem_addr(wb_maddr), .mem_data_out(wb_mdo),
    .mem_ready(wb_mrdy), .mem_data_block(m_data));

  l2_cache_wb #(.WRITE_BACK(1'b0)) dut_wt (
    .clk(clk), .rst_n(rst_n),
    .l1_req_valid(l1_valid & sel), .l1_req_write(l1_write), .l1_req_addr(l1_addr),
    .l1_req_wdata(l1_wdata), .l1_req_ready(wt_ready),
    .l1_resp_valid(wt_rv), .l1_resp_hit(wt_hit), .l1_resp_rdata(wt_rdata),
    .mem_read(wt_mr), .mem_write(wt_mw), .mem_addr(wt_maddr), .mem_data_out(wt_mdo),
    .mem_ready(wt_mrdy), .mem_data_block(m_data));

  int n_chk = 0;
  int n_fail = 0;

  function automatic blk_t blk(input logic [15:0] s);
    blk_t b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = {s, 8'hA5, 8'(i)};
    return b;
  endfunction

  task automatic chk(input string nm, input blk_t act, input blk_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural memory: unwritten blocks read back as blk(address).
  blk_t mstore [logic [15:0]];
  typedef struct { bit wr; logic [15:0] addr; blk_t data; } op_t;
  op_t ops[$];
  int  mem_lat = 3;
  bit  hold_mem = 1'b0;
  int  wait_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_ready  = 1'b0;
      wait_cnt = 0;
    end else if (m_ready) begin
      m_ready  = 1'b0;
      wait_cnt = 0;
    end else if ((a_mr || a_mw) && !hold_mem) begin
      if (wait_cnt >= mem_lat - 1) begin
        m_ready = 1'b1;
        m_data  = mstore.exists(a_maddr) ? mstore[a_maddr] : blk(a_maddr);
      end else begin
        wait_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    if (a_mr && a_mw) begin
      n_fail++;
      $display("FAIL mem_excl: read=%b write=%b", a_mr, a_mw);
    end
    if (rst_n && m_ready && a_mw) begin
      mstore[a_maddr] = a_mdo;
      ops.push_back('{1'b1, a_maddr, a_mdo});
    end else if (rst_n && m_ready && a_mr) begin
      ops.push_back('{1'b0, a_maddr, m_data});
    end
  end

  // Called at a negedge with the selected cache idle; returns at a negedge.
  task automatic do_req(input bit wr, input logic [15:0] addr, input blk_t wd,
                        output bit hit, output blk_t rd, output int lat);
    int t = 0;
    hit = 1'b0; rd = '0; lat = 0;
    l1_write = wr; l1_addr = addr; l1_wdata = wd; l1_valid = 1'b1;
    while (!a_ready && t < 200) begin @(negedge clk); t++; end
    if (!a_ready) begin
      n_fail++; l1_valid = 1'b0;
      $display("FAIL accept_timeout: addr %h not accepted", addr);
      return;
    end
    @(negedge clk);
    lat = 1;
    l1_valid = 1'b0; l1_write = ~wr; l1_addr = ~addr; l1_wdata = ~wd;
    while (!a_rv && lat < 200) begin @(negedge clk); lat++; end
    if (!a_rv) begin
      n_fail++;
      $display("FAIL resp_timeout: addr %h got no response", addr);
      return;
    end
    hit = a_hit;
    rd  = a_rdata;
    @(negedge clk);
  endtask

  typedef struct {
    bit sel; bit wr; logic [15:0] addr; logic [15:0] wseed;
    bit hit; logic [15:0] rseed; int nwr; int nrd;
    logic [15:0] maddr; logic [15:0] wbseed; int lat;
  } vec_t;
  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit   hit;
    blk_t rd;
    int   lat, t, nw, nr;

    //                sel wr addr      wseed     hit rseed     nwr nrd maddr     wbseed    lat
    vecs.push_back('{0, 0, 16'h0040, 16'h0000, 0, 16'h0040, 0, 1, 16'h0040, 16'h0000, 5});
    vecs.push_back('{0, 0, 16'h0045, 16'h0000, 1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 2});
    vecs.push_back('{0, 1, 16'h0040, 16'hD001, 1, 16'hD001, 0, 0, 16'h0000, 16'h0000, 2});
    vecs.push_back('{0, 0, 16'h0040, 16'h0000, 1, 16'hD001, 0, 0, 16'h0000, 16'h0000, 2});
    vecs.push_back('{0, 1, 16'h0088, 16'hD002, 0, 16'hD002, 0, 0, 16'h0000, 16'h0000, 2});
    vecs.push_back('{0, 0, 16'h0088, 16'h0000, 1, 16'hD002, 0, 0, 16'h0000, 16'h0000, 2});
    vecs.push_back('{0, 0, 16'h0140, 16'h0000, 0, 16'h0140, 0, 1, 16'h0140, 16'h0000, 5});
    vecs.push_back('{0, 0, 16'h0240, 16'h0000, 0, 16'h0240, 0, 1, 16'h0240, 16'h0000, 5});
    vecs.push_back('{0, 0, 16'h0340, 16'h0000, 0, 16'h0340, 0, 1, 16'h0340, 16'h0000, 5});
    vecs.push_back('{0, 0, 16'h0440, 16'h0000, 0, 16'h0440, 1, 1, 16'h0040, 16'hD001, 9});
    vecs.push_back('{0, 0, 16'h0140, 16'h0000, 1, 16'h0140, 0, 0, 16'h0000, 16'h0000, 2});
    vecs.push_back('{0, 0, 16'h0040, 16'h0000, 0, 16'hD001, 0, 1, 16'h0040, 16'h0000, 5});
    vecs.push_back('{1, 1, 16'h0080, 16'hD003, 0, 16'hD003, 1, 0, 16'h0080, 16'hD003, 5});
    vecs.push_back('{1, 0, 16'h0080, 16'h0000, 1, 16'hD003, 0, 0, 16'h0000, 16'h0000, 2});
    vecs.push_back('{1, 1, 16'h0080, 16'hD004, 1, 16'hD004, 1, 0, 16'h0080, 16'hD004, 5});
    vecs.push_back('{1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 16'h0000, 5});
    vecs.push_back('{1, 0, 16'h0100, 16'h0000, 0, 16'h0100, 0, 1, 16'h0100, 16'h0000, 5});
    vecs.push_back('{1, 0, 16'h0200, 16'h0000, 0, 16'h0200, 0, 1, 16'h0200, 16'h0000, 5});
    vecs.push_back('{1, 0, 16'h0300, 16'h0000, 0, 16'h0300, 0, 1, 16'h0300, 16'h0000, 5});
    vecs.push_back('{1, 0, 16'h0080, 16'h0000, 0, 16'hD004, 0, 1, 16'h0080, 16'h0000, 5});

    rst_n = 1'b0; sel = 1'b0; l1_valid = 1'b0; l1_write = 1'b0;
    l1_addr = '0; l1_wdata = '0; m_ready = 1'b0; m_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", blk_t'({a_ready, a_rv, a_hit, a_mr, a_mw, a_maddr}), '0);
    chk("rst_rdata", a_rdata, '0);
    chk("rst_mdata", a_mdo, '0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", blk_t'(a_ready), blk_t'(1));
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      sel = vecs[i].sel;
      ops.delete();
      do_req(vecs[i].wr, vecs[i].addr, blk(vecs[i].wseed), hit, rd, lat);
      nw = 0; nr = 0;
      foreach (ops[k]) if (ops[k].wr) nw++; else nr++;
      chk($sformatf("v%0d_hit", i), blk_t'(hit), blk_t'(vecs[i].hit));
      chk($sformatf("v%0d_rdata", i), rd, blk(vecs[i].rseed));
      chk($sformatf("v%0d_nwr", i), blk_t'(nw), blk_t'(vecs[i].nwr));
      chk($sformatf("v%0d_nrd", i), blk_t'(nr), blk_t'(vecs[i].nrd));
      if (ops.size() > 0 && vecs[i].nwr + vecs[i].nrd > 0) begin
        chk($sformatf("v%0d_first_op_wr", i), blk_t'(ops[0].wr), blk_t'(vecs[i].nwr > 0));
        chk($sformatf("v%0d_first_op_addr", i), blk_t'(ops[0].addr), blk_t'(vecs[i].maddr));
        if (vecs[i].nwr > 0)
          chk($sformatf("v%0d_wb_data", i), ops[0].data, blk(vecs[i].wbseed));
      end
      if (vecs[i].lat != 0)
        chk($sformatf("v%0d_latency", i), blk_t'(lat), blk_t'(vecs[i].lat));
    end

    // Memory stalls a refill for 10 cycles while a second request waits.
    sel = 1'b0; ops.delete(); hold_mem = 1'b1;
    l1_write = 1'b0; l1_addr = 16'h1000; l1_valid = 1'b1;
    @(negedge clk);
    l1_addr = 16'h3000;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall_c%0d", i), blk_t'({a_mr, a_mw, a_ready, a_maddr}),
          blk_t'({1'b1, 1'b0, 1'b0, 16'h1000}));
      @(negedge clk);
    end
    hold_mem = 1'b0;
    t = 0;
    while (!a_rv && t < 50) begin @(negedge clk); t++; end
    l1_valid = 1'b0;
    chk("stall_resp", blk_t'({a_rv, a_hit}), blk_t'(2'b10));
    chk("stall_rdata", a_rdata, blk(16'h1000));
    repeat (2) @(negedge clk);
    chk("stall_single_op", blk_t'(ops.size()), blk_t'(1));
    chk("stall_idle_ready", blk_t'(a_ready), blk_t'(1));

    // Reset while a refill is outstanding.
    ops.delete(); hold_mem = 1'b1;
    l1_write = 1'b0; l1_addr = 16'h2000; l1_valid = 1'b1;
    @(negedge clk);
    l1_valid = 1'b0;
    t = 0;
    while (!a_mr && t < 10) begin @(negedge clk); t++; end
    chk("abort_pre_mem_read", blk_t'(a_mr), blk_t'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", blk_t'({a_ready, a_rv, a_hit, a_mr, a_mw, a_maddr}), '0);
    chk("abort_rdata", a_rdata, '0);
    chk("abort_mdata", a_mdo, '0);
    @(negedge clk);
    rst_n = 1'b1; hold_mem = 1'b0;
    @(negedge clk);
    do_req(1'b0, 16'h2000, '0, hit, rd, lat);
    chk("abort_reread_hit", blk_t'(hit), blk_t'(0));
    chk("abort_reread_rdata", rd, blk(16'h2000));
    do_req(1'b0, 16'h0040, '0, hit, rd, lat);
    chk("post_rst_0040_hit", blk_t'(hit), blk_t'(0));
    chk("post_rst_0040_rdata", rd, blk(16'hD001));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_cache_wb.md
Name: l2_cache_wb

Overview:
Parametrised set-associative L2 cache that sits between the L1 cache and main memory and moves whole blocks on both sides. It extends the team's write-through L2 with a selectable write-back policy (per-line dirty bits) and true-LRU replacement. Dirty victims are written back before the replacing block is installed. The L1 side uses a valid/ready request handshake with request capture, and the memory side uses a level-held handshake.

Parameters:
DATA_WIDTH, 32, bits per word
ADDR_WIDTH, 16, word address width
BLOCK_WORDS, 8, words per block (power of two, >=2)
NUM_SETS, 16, sets (power of two, >=2)
NUM_WAYS, 4, ways per set (power of two, >=2)
WRITE_BACK, 1, 1 = write-back/write-allocate; 0 = write-through/write-allocate

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
l1_req_valid  in  1  L1 request present
l1_req_write  in  1  1 = block write, 0 = block read
l1_req_addr  in  ADDR_WIDTH  word address; offset bits ignored
l1_req_wdata  in  BLOCK_WORDS*DATA_WIDTH  write block (word 0 in LSBs)
l1_req_ready  out  1  request accepted when valid&&ready
l1_resp_valid  out  1  one-cycle response pulse
l1_resp_hit  out  1  request hit, qualified by l1_resp_valid
l1_resp_rdata  out  BLOCK_WORDS*DATA_WIDTH  read block (writes: echo of write data)
mem_read  out  1  block read request, level-held
mem_write  out  1  block write request, level-held
mem_addr  out  ADDR_WIDTH  block-aligned address
mem_data_out  out  BLOCK_WORDS*DATA_WIDTH  write block
mem_ready  in  1  completes current mem op
mem_data_block  in  BLOCK_WORDS*DATA_WIDTH  read data, valid with mem_ready

Behaviour:
- Address split: offset = low log2(BLOCK_WORDS) bits; index = next log2(NUM_SETS) bits; tag = remainder.
- Reset (async, immediate): state IDLE. All outputs 0 except l1_req_ready = 1 after reset release. All valid and dirty bits cleared. LRU age of way w = w. Data and tag arrays are not reset.
- States: IDLE, TAG_CHECK, WRITEBACK, REFILL, RESPOND.
- IDLE:
  - l1_req_ready = 1.
  - On valid&&ready, capture addr, write, and wdata into internal registers, then go to TAG_CHECK.
  - All later decisions use the captured values; L1 may change its inputs after acceptance.
- TAG_CHECK (l1_req_ready = 0):
  - Hit (valid && tag match):
    - Read: go to RESPOND.
    - Write, WRITE_BACK = 1: update data, set dirty, go to RESPOND.
    - Write, WRITE_BACK = 0: update data, go to WRITEBACK with mem_addr = request block address.
  - Miss, victim selection: lowest-index invalid way; otherwise the way with age NUM_WAYS-1.
  - Miss, victim valid and dirty: go to WRITEBACK with mem_addr = {victim tag, index, 0}, mem_data_out = victim data.
  - Miss, otherwise:
    - Read: go to REFILL.
    - Write: install tag and data, set valid, set dirty = WRITE_BACK. Then WRITE_BACK = 1 goes to RESPOND; WRITE_BACK = 0 goes to WRITEBACK (write-through).
- WRITEBACK:
  - mem_write = 1 with stable addr/data until mem_ready is sampled high.
  - Victim case: clear victim dirty, then:
    - Read miss: go to REFILL.
    - Write miss: install write data, set valid, set dirty = WRITE_BACK, go to RESPOND.
  - Write-through case: go to RESPOND.
- REFILL:
  - mem_read = 1, mem_addr = request block address, held until mem_ready.
  - On mem_ready: install mem_data_block, tag, valid=1, dirty=0; latch data for the response; go to RESPOND.
- RESPOND:
  - l1_resp_valid = 1 for exactly one cycle; l1_resp_hit reflects the TAG_CHECK result.
  - The LRU update happens here: accessed way age = 0; ways in the same set with age < old age increment. Go to IDLE.
- Latency: read/write hit in WRITE_BACK = 1 mode gives resp_valid 2 cycles after the accept edge. Misses add 1 cycle per mem op plus memory wait.
- mem_read and mem_write are never both high. mem_ready is ignored while neither is high. No L1 backpressure on the response.
- Reset mid-operation aborts any in-flight mem op; no partial install occurs.
- Lines are never dirty in write-through mode, so eviction in that mode produces no write-back.

Test Plan:
- Cold read 0x0040 (index 8); mem_ready after 3 cycles with block B -> mem_read@0x0040 held 3 cycles; resp hit=0, rdata=B. Re-read 0x0040 -> hit=1, resp 2 cycles after accept, no mem activity.
- WRITE_BACK=1: write 0x0040 data D on a resident line -> resp hit=1, mem_write never asserted; read 0x0040 returns D.
- Eviction: write-miss 0x0040 (D, dirty); read 0x0140, 0x0240, 0x0340; read 0x0440 -> mem_write@0x0040 data D first, then mem_read@0x0440. A later read of 0x0140 hits.
- WRITE_BACK=0: write 0x0080 D -> mem_write@0x0080 data D; resp only after mem_ready. Filling set 0 and evicting 0x0080 gives no mem_write.
- Hold mem_ready low 10 cycles during refill -> mem_read and mem_addr stable, l1_req_ready=0, second request not accepted.
- Assert rst_n low while mem_read=1 -> all outputs 0 immediately; after release, read of same address misses (hit=0).
